// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root unit.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned W_DEFAULT = 16;

  // Root width for a W-bit radicand.
  function automatic int unsigned root_width(input int unsigned w);
    return w / 2;
  endfunction

  // Iteration counter width: must hold R-1.
  function automatic int unsigned cnt_width(input int unsigned r);
    return $clog2(r);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration (purely combinational).
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W/2+1:0] rem,
  input  logic [W/2-1:0] root,
  input  logic [1:0]     bits,
  output logic [W/2+1:0] rem_next,
  output logic [W/2-1:0] root_next
);

  localparam int unsigned R  = root_width(W);
  localparam int unsigned RW = R + 2;
  localparam int unsigned XW = R + 4;

  logic [XW-1:0] shifted;
  logic [XW-1:0] trial;
  logic [XW-1:0] diff;
  logic          ge;

  // The true remainder never exceeds R+1 bits, so truncating the widened
  // intermediates back to R+2 bits loses nothing.
  always_comb begin
    shifted   = {rem, bits};
    trial     = {2'b00, root, 2'b01};
    diff      = shifted - trial;
    ge        = (shifted >= trial);
    rem_next  = ge ? RW'(diff) : RW'(shifted);
    root_next = ge ? R'({root, 1'b1}) : R'({root, 1'b0});
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: floor(sqrt(in_data)) and remainder,
// one root bit per cycle over a valid/ready handshake.
// Optional: define ISQRT_EXACT_EN to register a perfect-square flag.
module isqrt_seq
  import isqrt_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W/2-1:0] out_root,
  output logic [W/2:0]   out_rem,
  output logic           out_exact
);

  localparam int unsigned R  = root_width(W);
  localparam int unsigned CW = cnt_width(R);

  state_t        state, state_next;
  logic [W-1:0]  rad;
  logic [R+1:0]  rem, rem_next;
  logic [R-1:0]  root, root_next;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == '0);

  isqrt_step #(.W(W)) u_step (
    .rem       (rem),
    .root      (root),
    .bits      (rad[W-1:W-2]),
    .rem_next  (rem_next),
    .root_next (root_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Iteration datapath and result registers (results load only on BUSY->DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      out_root <= '0;
      out_rem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rad  <= in_data;
            rem  <= '0;
            root <= '0;
            cnt  <= CW'(R - 1);
          end
        end
        BUSY: begin
          rad  <= {rad[W-3:0], 2'b00};
          rem  <= rem_next;
          root <= root_next;
          cnt  <= cnt - CW'(1);
          if (last) begin
            out_root <= root_next;
            out_rem  <= rem_next[R:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ISQRT_EXACT_EN
  // Perfect-square flag, captured alongside the result.
  always_ff @(posedge clk) begin
    if (!rst_n)                      out_exact <= 1'b0;
    else if ((state == BUSY) && last) out_exact <= (rem_next == '0);
  end
`else
  assign out_exact = 1'b0;
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq (W=16): directed vector table plus
// hand-written sequences for throughput, backpressure and mid-BUSY reset.
module tb_isqrt_seq;

  localparam int unsigned W = 16;
  localparam int unsigned R = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_root;
  logic [8:0]   out_rem;
  logic         out_exact;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isqrt_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_rem   (out_rem),
    .out_exact (out_exact)
  );

  typedef struct {
    logic [15:0] data;
    logic [7:0]  root;
    logic [8:0]  rem;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int exp_exact(input int rem);
`ifdef ISQRT_EXACT_EN
    return (rem == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns cycles waited.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  // Full transaction from IDLE: accept, check latency and result, handshake.
  task automatic do_op(input logic [15:0] data, input int root, input int rem,
                       input string name);
    int lat;
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    in_data  = data;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    wait_valid(lat);
    check({name, "_latency"}, lat, R);
    check({name, "_root"}, out_root, root);
    check({name, "_rem"}, out_rem, rem);
    check({name, "_exact"}, out_exact, exp_exact(rem));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int prev;
    int held;
    int seen;

    vecs[0] = '{16'd0,     8'd0,   9'd0};
    vecs[1] = '{16'hFFFF,  8'd255, 9'd510};
    vecs[2] = '{16'd1000,  8'd31,  9'd39};
    vecs[3] = '{16'd36864, 8'd192, 9'd0};
    vecs[4] = '{16'd2,     8'd1,   9'd1};
    vecs[5] = '{16'd15,    8'd3,   9'd6};
    vecs[6] = '{16'd99,    8'd9,   9'd18};
    vecs[7] = '{16'd65025, 8'd255, 9'd0};
    vecs[8] = '{16'd65024, 8'd254, 9'd508};
    vecs[9] = '{16'd1,     8'd1,   9'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_root", out_root, 0);
    check("rst_out_rem", out_rem, 0);
    check("rst_out_exact", out_exact, 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].data, vecs[i].root, vecs[i].rem, $sformatf("vec%0d", i));

    // Results hold in IDLE after the handshake.
    check("idle_hold_root", out_root, 1);
    check("idle_hold_valid", out_valid, 0);

    // Back-to-back perfect squares with no backpressure: 10-cycle spacing.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev      = 0;
    for (int k = 0; k < 256; k++) begin
      in_data = 16'(k * k);
      step();
      wait_valid(lat);
      check($sformatf("sweep_root_k%0d", k), out_root, k);
      check($sformatf("sweep_rem_k%0d", k), out_rem, 0);
      if (k > 0) check($sformatf("sweep_spacing_k%0d", k), cyc - prev, 10);
      prev = cyc;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Backpressure: result held for 5 cycles while out_ready is low.
    in_data  = 16'd50;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", lat, R);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid && out_root == 8'd7 && out_rem == 9'd1 && !in_ready) held++;
    end
    check("bp_held_cycles", held, 5);
    check("bp_root", out_root, 7);
    check("bp_rem", out_rem, 1);
    check("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Reset during the 3rd BUSY cycle aborts the operation.
    in_data  = 16'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_root", out_root, 0);
    check("abort_out_rem", out_rem, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    do_op(16'd81, 9, 0, "post_abort");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
